// File: rtl/way_allocator_pkg.sv
// way_allocator_pkg: shared types and helpers for the per-set way allocator.
//   state_t : IDLE / LOOKUP / COMMIT encoding of the allocation FSM.
//   log2    : ceiling log2, used to size the round-robin victim pointer.
package way_allocator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/way_allocator_select.sv
// empty_way_select: combinational lowest-free-way finder.
//   way_valid      in  NUM_WAYS  ways currently in use
//   next_empty_way out NUM_WAYS  one-hot lowest clear bit of way_valid (0 if none)
//   valid          out 1         at least one way is free
module empty_way_select #(
  parameter int unsigned NUM_WAYS = 8
) (
  input  logic [NUM_WAYS-1:0] way_valid,
  output logic [NUM_WAYS-1:0] next_empty_way,
  output logic                valid
);

  logic [NUM_WAYS-1:0] free;

  // Isolate lowest set bit of the free mask: x & -x.
  always_comb begin
    free           = ~way_valid;
    next_empty_way = free & (~free + NUM_WAYS'(1));
    valid          = |free;
  end

endmodule

// File: rtl/way_allocator.sv
// way_allocator: per-set way allocation controller.
// Keeps a valid vector and a round-robin victim pointer per set; on a request
// it picks the lowest free way of the set, or the round-robin victim when the
// set is full, and commits the choice back into the set state.
//   clock, reset      clock and asynchronous active-high reset
//   alloc_req/index   allocation request for one set (hold until alloc_ready)
//   alloc_ready       FSM is idle and can accept a request
//   alloc_done        one-cycle pulse when the allocation is committed
//   alloc_way         one-hot allocated way, held until the next alloc_done
//   alloc_evict       allocated way was already valid (victim chosen)
//   inv_req/index/way invalidate: clear inv_way bits of the indexed set
module way_allocator
  import way_allocator_pkg::*;
#(
  parameter int unsigned NUM_WAYS   = 8,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_req,
  input  logic [INDEX_BITS-1:0] alloc_index,
  output logic                  alloc_ready,
  output logic                  alloc_done,
  output logic [NUM_WAYS-1:0]   alloc_way,
  output logic                  alloc_evict,
  input  logic                  inv_req,
  input  logic [INDEX_BITS-1:0] inv_index,
  input  logic [NUM_WAYS-1:0]   inv_way
);

  localparam int unsigned NUM_SETS = 1 << INDEX_BITS;
  localparam int unsigned PTR_W    = log2(NUM_WAYS);

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [NUM_WAYS-1:0]     snap_q;
  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     valid_d [NUM_SETS];
  logic [PTR_W-1:0]        rr_q    [NUM_SETS];
  logic [PTR_W-1:0]        rr_d    [NUM_SETS];

  logic [NUM_WAYS-1:0]     sel_way;
  logic                    sel_valid;
  logic                    accept;
  logic                    commit;
  logic [NUM_WAYS-1:0]     result;
  logic                    evict;
  logic                    inv_hit_idx;

  empty_way_select #(
    .NUM_WAYS (NUM_WAYS)
  ) u_select (
    .way_valid      (snap_q),
    .next_empty_way (sel_way),
    .valid          (sel_valid)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and commit decision.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    evict   = ~sel_valid;
    result  = sel_valid ? sel_way : (NUM_WAYS'(1) << rr_q[idx_q]);
    case (state_q)
      IDLE: begin
        if (alloc_req) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request index latch and set snapshot (with same-cycle invalidate folded in).
  always_comb inv_hit_idx = inv_req && (inv_index == idx_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      snap_q <= '0;
    end else begin
      if (accept) idx_q <= alloc_index;
      if (state_q == LOOKUP)
        snap_q <= valid_q[idx_q] & ~(inv_hit_idx ? inv_way : NUM_WAYS'(0));
    end
  end

  // Per-set next state: invalidate first, then the committed way is set.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      valid_d[s] = valid_q[s];
      rr_d[s]    = rr_q[s];
      if (inv_req && (inv_index == INDEX_BITS'(s)))
        valid_d[s] = valid_d[s] & ~inv_way;
      if (commit && (idx_q == INDEX_BITS'(s))) begin
        valid_d[s] = valid_d[s] | result;
        if (evict) rr_d[s] = rr_q[s] + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= valid_d[s];
        rr_q[s]    <= rr_d[s];
      end
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alloc_ready <= 1'b0;
      alloc_done  <= 1'b0;
      alloc_way   <= '0;
      alloc_evict <= 1'b0;
    end else begin
      alloc_ready <= (state_d == IDLE);
      alloc_done  <= commit;
      if (commit) begin
        alloc_way   <= result;
        alloc_evict <= evict;
      end
    end
  end

endmodule

// File: tb/tb_way_allocator.sv
module tb_way_allocator;

  localparam int NW = 8;
  localparam int IB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          alloc_req;
  logic [IB-1:0] alloc_index;
  logic          alloc_ready;
  logic          alloc_done;
  logic [NW-1:0] alloc_way;
  logic          alloc_evict;
  logic          inv_req;
  logic [IB-1:0] inv_index;
  logic [NW-1:0] inv_way;

  int tests = 0;
  int fails = 0;

  // Reference model: per-set valid bits and victim pointer.
  logic [7:0] m_valid [16];
  int         m_rr    [16];

  way_allocator #(.NUM_WAYS(NW), .INDEX_BITS(IB)) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_index (alloc_index),
    .alloc_ready (alloc_ready),
    .alloc_done  (alloc_done),
    .alloc_way   (alloc_way),
    .alloc_evict (alloc_evict),
    .inv_req     (inv_req),
    .inv_index   (inv_index),
    .inv_way     (inv_way)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 8'h00;
      m_rr[i]    = 0;
    end
  endfunction

  function automatic void model_inv(input int s, input logic [7:0] m);
    m_valid[s] = m_valid[s] & ~m;
  endfunction

  // Lowest free way, else round-robin victim (pointer then advances).
  function automatic void model_pick(input int s, output logic [7:0] w, output logic e);
    w = 8'h00;
    e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!m_valid[s][i]) begin
        w = 8'(1) << i;
        e = 1'b0;
        break;
      end
    end
    if (e) begin
      w = 8'(1) << m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % 8;
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!alloc_ready && n < 10) begin
      step();
      n++;
    end
    check("ready_wait", 32'(alloc_ready), 32'd1);
  endtask

  // inv_at: 0 none, 1 invalidate during LOOKUP, 2 invalidate during COMMIT.
  task automatic do_alloc(input int s, input int inv_at, input int inv_s, input logic [7:0] inv_m,
                          output logic [7:0] w_got, output logic e_got);
    logic [7:0] w;
    logic e;
    wait_ready();
    alloc_req   = 1'b1;
    alloc_index = IB'(s);
    step();
    alloc_req   = 1'b0;
    alloc_index = IB'($urandom);
    check("ready_lookup", 32'(alloc_ready), 32'd0);
    check("done_lookup", 32'(alloc_done), 32'd0);
    if (inv_at == 1) begin
      inv_req = 1'b1; inv_index = IB'(inv_s); inv_way = inv_m;
    end
    step();
    inv_req = 1'b0;
    if (inv_at == 1) model_inv(inv_s, inv_m);
    model_pick(s, w, e);
    check("ready_commit", 32'(alloc_ready), 32'd0);
    check("done_commit", 32'(alloc_done), 32'd0);
    if (inv_at == 2) begin
      inv_req = 1'b1; inv_index = IB'(inv_s); inv_way = inv_m;
    end
    step();
    inv_req = 1'b0;
    if (inv_at == 2) model_inv(inv_s, inv_m);
    m_valid[s] = m_valid[s] | w;
    check("done_pulse", 32'(alloc_done), 32'd1);
    check("alloc_way", 32'(alloc_way), 32'(w));
    check("alloc_evict", 32'(alloc_evict), 32'(e));
    check("ready_after", 32'(alloc_ready), 32'd1);
    w_got = alloc_way;
    e_got = alloc_evict;
    step();
    check("done_fall", 32'(alloc_done), 32'd0);
    check("way_hold", 32'(alloc_way), 32'(w));
  endtask

  task automatic do_inv(input int s, input logic [7:0] m);
    inv_req = 1'b1; inv_index = IB'(s); inv_way = m;
    step();
    inv_req = 1'b0;
    model_inv(s, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    logic e;
    logic [7:0] mw;
    logic me;

    reset = 1'b1; alloc_req = 1'b0; alloc_index = '0;
    inv_req = 1'b0; inv_index = '0; inv_way = '0;
    model_reset();
    step(); step();
    check("rst_ready", 32'(alloc_ready), 32'd0);
    check("rst_done", 32'(alloc_done), 32'd0);
    check("rst_way", 32'(alloc_way), 32'd0);
    check("rst_evict", 32'(alloc_evict), 32'd0);
    reset = 1'b0;
    step();
    check("ready_post_rst", 32'(alloc_ready), 32'd1);

    // Fill set 3 in order.
    for (int i = 0; i < 8; i++) begin
      do_alloc(3, 0, 0, 8'h00, w, e);
      check("fill3_way", 32'(w), 32'd1 << i);
      check("fill3_evict", 32'(e), 32'd0);
    end
    // Evictions wrap from pointer 0.
    do_alloc(3, 0, 0, 8'h00, w, e);
    check("ev9_way", 32'(w), 32'h01);
    check("ev9_evict", 32'(e), 32'd1);
    do_alloc(3, 0, 0, 8'h00, w, e);
    check("ev10_way", 32'(w), 32'h02);
    check("ev10_evict", 32'(e), 32'd1);
    do_alloc(5, 0, 0, 8'h00, w, e);
    check("set5_way", 32'(w), 32'h01);
    check("set5_evict", 32'(e), 32'd0);

    // Invalidate frees a way; pointer is untouched.
    do_inv(3, 8'h10);
    do_alloc(3, 0, 0, 8'h00, w, e);
    check("inv3_way", 32'(w), 32'h10);
    check("inv3_evict", 32'(e), 32'd0);
    do_alloc(3, 0, 0, 8'h00, w, e);
    check("ptr3_way", 32'(w), 32'h04);
    check("ptr3_evict", 32'(e), 32'd1);

    // Fill set 7, then invalidate during LOOKUP.
    for (int i = 0; i < 8; i++) do_alloc(7, 0, 0, 8'h00, w, e);
    do_alloc(7, 1, 7, 8'h20, w, e);
    check("lk_inv_way", 32'(w), 32'h20);
    check("lk_inv_evict", 32'(e), 32'd0);
    // Invalidate all of set 7 during COMMIT: victim still lands valid.
    do_alloc(7, 2, 7, 8'hFF, w, e);
    check("cm_inv_way", 32'(w), 32'h01);
    check("cm_inv_evict", 32'(e), 32'd1);
    do_alloc(7, 0, 0, 8'h00, w, e);
    check("cm_inv_next", 32'(w), 32'h02);

    // Request held continuously: one accept every 3 cycles.
    wait_ready();
    alloc_req = 1'b1; alloc_index = IB'(5);
    for (int k = 0; k < 9; k++) begin
      step();
      check("hold_ready", 32'(alloc_ready), 32'((k % 3) == 2));
      check("hold_done", 32'(alloc_done), 32'((k % 3) == 2));
      if ((k % 3) == 2) begin
        model_pick(5, mw, me);
        m_valid[5] = m_valid[5] | mw;
        check("hold_way", 32'(alloc_way), 32'(mw));
        check("hold_evict", 32'(alloc_evict), 32'(me));
      end
    end
    alloc_req = 1'b0;
    step();

    // Reset during LOOKUP aborts the request.
    wait_ready();
    alloc_req = 1'b1; alloc_index = IB'(3);
    step();
    alloc_req = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(alloc_ready), 32'd0);
    step(); step();
    check("abort_done", 32'(alloc_done), 32'd0);
    reset = 1'b0;
    model_reset();
    step();
    check("abort_ready_back", 32'(alloc_ready), 32'd1);
    check("abort_no_done", 32'(alloc_done), 32'd0);
    do_alloc(3, 0, 0, 8'h00, w, e);
    check("abort_way", 32'(w), 32'h01);
    check("abort_evict", 32'(e), 32'd0);

    // Random mix on a few sets so they fill, evict and get invalidated.
    for (int it = 0; it < 200; it++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if (op == 0) begin
        do_inv(int'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        do_alloc(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), 8'($urandom), w, e);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
